// File: rtl/mprf_wb_pkg.sv
// ============================================================================
// mprf_wb_pkg : shared defaults for the write-back register file
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mprf_wb_pkg;
  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned PEND_W_DEF = 2;
  localparam int unsigned NREGS      = 32;
endpackage

`default_nettype wire

// File: rtl/wb_pend_cnt.sv
// ============================================================================
// wb_pend_cnt : saturating up/down counter of outstanding write-backs
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_pend_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_max
);

  logic [W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; both directions saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count  = cnt_q;
  assign is_max = (cnt_q == '1);

endmodule

`default_nettype wire

// File: rtl/mprf_wb.sv
// ============================================================================
// mprf_wb  : 31-entry register file with per-register pending write tracking
// Revision : 1.0
// ============================================================================
`default_nettype none

module mprf_wb
  import mprf_wb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned PEND_W = PEND_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_vld,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  input  logic [4:0]      m2_sel,
  input  logic [XLEN-1:0] m2_data,
  input  logic [4:0]      rs0_sel,
  input  logic [4:0]      rs1_sel,
  output logic [XLEN-1:0] rs0_word,
  output logic [XLEN-1:0] rs1_word,
  output logic            rs0_pend,
  output logic            rs1_pend,
  output logic            wb_idle,
  output logic            wb_orphan
);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [PEND_W-1:0] cnt    [NREGS];
  logic [NREGS-1:0]  is_max;
  logic              accept;
  logic              any_pend;
  logic              orphan_d;
  logic              wb_idle_q, wb_orphan_q;

  assign cnt[0]    = '0;
  assign is_max[0] = 1'b0;

  assign issue_stall = issue_vld && (issue_rd != 5'd0) && is_max[issue_rd] && (m2_sel != issue_rd);
  assign accept      = issue_vld && (issue_rd != 5'd0) && !issue_stall;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    wb_pend_cnt #(.W(PEND_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (accept && (issue_rd == 5'(r))),
      .dec    (m2_sel == 5'(r)),
      .count  (cnt[r]),
      .is_max (is_max[r])
    );
  end

  always_comb begin
    any_pend = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (cnt[r] != '0) any_pend = 1'b1;
    end
  end

  // A write-back landing this cycle already retires one pending write.
  always_comb begin
    rs0_word = (rs0_sel == 5'd0) ? '0 : (rs0_sel == m2_sel) ? m2_data : regs_q[rs0_sel];
    rs1_word = (rs1_sel == 5'd0) ? '0 : (rs1_sel == m2_sel) ? m2_data : regs_q[rs1_sel];
    rs0_pend = (cnt[rs0_sel] > PEND_W'(1)) || ((cnt[rs0_sel] == PEND_W'(1)) && (m2_sel != rs0_sel));
    rs1_pend = (cnt[rs1_sel] > PEND_W'(1)) || ((cnt[rs1_sel] == PEND_W'(1)) && (m2_sel != rs1_sel));
  end

  assign orphan_d = (m2_sel != 5'd0) && (cnt[m2_sel] == '0) && !(accept && (issue_rd == m2_sel));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      wb_idle_q   <= 1'b1;
      wb_orphan_q <= 1'b0;
    end else begin
      if (m2_sel != 5'd0) regs_q[m2_sel] <= m2_data;
      wb_idle_q <= !any_pend;
      if (orphan_d) wb_orphan_q <= 1'b1;
    end
  end

  assign wb_idle   = wb_idle_q;
  assign wb_orphan = wb_orphan_q;

endmodule

`default_nettype wire

// File: tb/tb_mprf_wb.sv
// ============================================================================
// tb_mprf_wb : scoreboard bench for mprf_wb against a behavioural model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_mprf_wb;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst, issue_vld, issue_stall;
  logic [4:0]  issue_rd, m2_sel, rs0_sel, rs1_sel;
  logic [31:0] m2_data, rs0_word, rs1_word;
  logic        rs0_pend, rs1_pend, wb_idle, wb_orphan;

  always #5 clk = ~clk;

  mprf_wb #(.XLEN(32), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .issue_vld(issue_vld), .issue_rd(issue_rd),
    .issue_stall(issue_stall), .m2_sel(m2_sel), .m2_data(m2_data),
    .rs0_sel(rs0_sel), .rs1_sel(rs1_sel), .rs0_word(rs0_word), .rs1_word(rs1_word),
    .rs0_pend(rs0_pend), .rs1_pend(rs1_pend), .wb_idle(wb_idle), .wb_orphan(wb_orphan)
  );

  typedef struct {
    logic [31:0] w0, w1;
    bit          p0, p1, st, idle, orph;
  } exp_t;

  exp_t        q[$];
  int          pc_m [32];
  logic [31:0] regs_m [32];
  bit          orph_m, idle_m, model_ok;
  int          total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_word(input logic [4:0] s, input logic [4:0] ws, input logic [31:0] wd);
    if (s == 0) return 32'd0;
    if (s == ws) return wd;
    return regs_m[s];
  endfunction

  function automatic bit m_pend(input logic [4:0] s, input logic [4:0] ws);
    int left;
    if (s == 0) return 1'b0;
    left = pc_m[s] - ((s == ws) ? 1 : 0);
    return left > 0;
  endfunction

  function automatic bit m_stall(input bit v, input logic [4:0] rd, input logic [4:0] ws);
    return v && (rd != 0) && (pc_m[rd] == MAXC) && (ws != rd);
  endfunction

  // One clock: drive inputs, predict outputs, then advance the model at the edge.
  task automatic cyc(input bit r, input bit v, input logic [4:0] rd, input logic [4:0] ws,
                     input logic [31:0] wd, input logic [4:0] s0, input logic [4:0] s1);
    exp_t e;
    bit   st, acc, all_zero;
    rst = r; issue_vld = v; issue_rd = rd; m2_sel = ws; m2_data = wd;
    rs0_sel = s0; rs1_sel = s1;
    st  = m_stall(v, rd, ws);
    acc = v && (rd != 0) && !st;
    if (model_ok) begin
      e.w0 = m_word(s0, ws, wd); e.w1 = m_word(s1, ws, wd);
      e.p0 = m_pend(s0, ws);     e.p1 = m_pend(s1, ws);
      e.st = st; e.idle = idle_m; e.orph = orph_m;
      q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin pc_m[i] = 0; regs_m[i] = 32'd0; end
      idle_m = 1'b1; orph_m = 1'b0; model_ok = 1'b1;
    end else begin
      all_zero = 1'b1;
      for (int i = 1; i < 32; i++) if (pc_m[i] != 0) all_zero = 1'b0;
      idle_m = all_zero;
      if (ws != 0 && pc_m[ws] == 0 && !(acc && rd == ws)) orph_m = 1'b1;
      if (ws != 0) regs_m[ws] = wd;
      if (!(acc && rd == ws)) begin
        if (acc) pc_m[rd] = pc_m[rd] + 1;
        if (ws != 0 && pc_m[ws] > 0) pc_m[ws] = pc_m[ws] - 1;
      end
    end
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rs0_word",    rs0_word,    e.w0);
        chk("rs1_word",    rs1_word,    e.w1);
        chk("rs0_pend",    rs0_pend,    e.p0);
        chk("rs1_pend",    rs1_pend,    e.p1);
        chk("issue_stall", issue_stall, e.st);
        chk("wb_idle",     wb_idle,     e.idle);
        chk("wb_orphan",   wb_orphan,   e.orph);
      end
    end
  end

  initial begin
    model_ok = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Dispatch to x5, write-back three cycles later with bypass.
    cyc(0, 1, 5, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 5, 32'h1234, 5, 5);
    cyc(0, 0, 0, 0, 0, 5, 0);

    // Saturate x7, then a same-cycle write-back lets the fourth through.
    repeat (3) cyc(0, 1, 7, 0, 0, 7, 0);
    cyc(0, 1, 7, 0, 0, 7, 0);
    cyc(0, 1, 7, 7, 32'h77, 7, 0);
    cyc(0, 1, 7, 0, 0, 7, 0);
    repeat (3) cyc(0, 0, 0, 7, 32'h70, 7, 0);
    cyc(0, 0, 0, 0, 0, 7, 0);

    // Write-back to x0 is dropped.
    cyc(0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 7);

    // Orphan write-back to x9.
    cyc(0, 0, 0, 9, 32'hA5A5_0009, 9, 0);
    chk("orphan_set", wb_orphan, 1'b1);
    cyc(0, 0, 0, 0, 0, 9, 9);
    cyc(0, 0, 0, 0, 0, 9, 0);
    chk("orphan_sticky", wb_orphan, 1'b1);

    // Reset with two writes pending to x3.
    cyc(0, 1, 3, 0, 0, 3, 0);
    cyc(0, 1, 3, 0, 0, 3, 0);
    cyc(1, 1, 3, 3, 32'hDEAD, 3, 9);
    chk("idle_after_rst", wb_idle, 1'b1);
    chk("orphan_after_rst", wb_orphan, 1'b0);
    cyc(0, 0, 0, 0, 0, 3, 9);

    // Randomised dispatch / write-back streams.
    for (int n = 0; n < 1500; n++) begin
      bit          r, v;
      logic [4:0]  rd, ws, s0, s1;
      logic [31:0] wd;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 9) < 6);
      rd = 5'($urandom_range(0, 6));
      ws = ($urandom_range(0, 9) < 4) ? 5'd0 : 5'($urandom_range(0, 6));
      wd = $urandom;
      s0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s1 = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 7));
      cyc(r, v, rd, ws, wd, s0, s1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mprf_wb.md
MPRF_WB -- requirements
Module: mprf_wb

Interface
REQ-001 SHALL take parameter XLEN, default 32, as the register word width (taken from the shared define file).
REQ-002 SHALL take parameter PEND_W, default 2, as the width of each per-register pending-write counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port issue_vld, input, 1 bit: a long-latency op (MUL/DIV or load) is dispatched this cycle.
REQ-006 SHALL have port issue_rd, input, 5 bits: destination register of the dispatched op.
REQ-007 SHALL have port issue_stall, output, 1 bit: the dispatch is refused this cycle.
REQ-008 SHALL have port m2_sel, input, 5 bits: write-back register select from the merged mem/mul channel; 0 = no write.
REQ-009 SHALL have port m2_data, input, XLEN bits: write-back data.
REQ-010 SHALL have ports rs0_sel and rs1_sel, input, 5 bits each: read selects.
REQ-011 SHALL have ports rs0_word and rs1_word, output, XLEN bits each: read data.
REQ-012 SHALL have ports rs0_pend and rs1_pend, output, 1 bit each: the operand still awaits a write-back.
REQ-013 SHALL have port wb_idle, output, 1 bit, registered: no write-back is outstanding for any register.
REQ-014 SHALL have port wb_orphan, output, 1 bit, sticky: a write-back arrived for a register with nothing outstanding.

Function
REQ-015 SHALL hold 31 registers x1..x31; x0 reads as 0, is never written, and never counts as pending.
REQ-016 SHALL write regs[m2_sel] <= m2_data whenever m2_sel != 0, with no handshake and one write per cycle.
REQ-017 SHALL keep a pending counter pc[r] for each r in 1..31, with range 0..2^PEND_W-1.
REQ-018 SHALL define an accepted dispatch as issue_vld & (issue_rd != 0) & ~issue_stall; it increments pc[issue_rd].
REQ-019 SHALL decrement pc[m2_sel] on each write-back with m2_sel != 0, saturating at 0.
REQ-020 SHALL leave pc unchanged when an accepted dispatch and a write-back target the same register in the same cycle.
REQ-021 SHALL assert issue_stall = issue_vld & (issue_rd != 0) & (pc[issue_rd] == max) & (m2_sel != issue_rd), combinationally.
REQ-022 SHALL produce reads combinationally, with bypass: if rsN_sel != 0 and rsN_sel == m2_sel, then rsN_word = m2_data; otherwise rsN_word = regs[rsN_sel].
REQ-023 SHALL drive rsN_pend = (pc[rsN_sel] minus one if a write-back to that register occurs this cycle, else pc[rsN_sel]) != 0, and 0 for x0.
REQ-024 SHALL make the effect of a same-cycle dispatch visible in rsN_pend from the next cycle only.
REQ-025 SHALL set wb_idle one cycle after every pc is 0 and clear it one cycle after any pc becomes non-zero.
REQ-026 SHALL set wb_orphan on the cycle after a write-back with m2_sel != 0 where pc[m2_sel] == 0 and there is no same-cycle accepted dispatch to that register; it stays set until rst.
REQ-027 SHALL still complete the data write of an orphan write-back; the orphan condition has no other side effect.

Reset
REQ-028 SHALL, on rst, clear all registers to 0, all pc to 0, and wb_orphan to 0, and set wb_idle to 1.
REQ-029 SHALL give rst priority over a simultaneous write-back or dispatch in the same cycle, so neither takes effect.
REQ-030 SHALL make a dispatch or write-back cycle that is interrupted by reset have no lasting effect.

Structure
REQ-031 SHALL take XLEN and PEND_W defaults from the shared define file; no new package types are needed.
REQ-032 SHALL instance the sub-module wb_pend_cnt 31 times: a saturating up/down counter with inc, dec, count and is_max.
REQ-033 SHALL keep the register array and bypass mux in mprf_wb itself.

Verification
REQ-034 SHALL cover: dispatch rd=5, write-back 5/0x1234 three cycles later -> rs0_pend(5)=1 over cycles 1-3, then 0 with rs0_word=0x1234 bypassed in the write-back cycle.
REQ-035 SHALL cover: three dispatches to rd=7 then a fourth -> the fourth sees issue_stall=1; a fourth with same-cycle write-back to 7 -> accepted, pc[7] stays 3.
REQ-036 SHALL cover: write-back to x0 with data 0xFFFFFFFF -> rs0_word(0)=0, pc unchanged, wb_orphan=0.
REQ-037 SHALL cover: write-back to x9 with nothing dispatched -> regs[9] is written and wb_orphan=1 from the next cycle until rst.
REQ-038 SHALL cover: rst asserted while pc[3]=2 -> next cycle all pend=0, wb_idle=1, rs words 0.
REQ-039 SHALL cover: random dispatch/write-back streams against a reference scoreboard -> no pend mismatch, and wb_idle matches the all-zero state delayed by one cycle.
